// File: rtl/ccr_branch_unit.sv
// Condition code register with SETC/CLRC, interrupt save/restore and branch resolution with a multi-cycle flush.
// Flags registered (1 cycle); branch decision combinational; o_flush high FLUSH_CYCLES cycles after a taken branch.
// Backpressure: i_stall freezes CCR and branch evaluation; flush counter and interrupt FSM keep running. Option: CCR_BYPASS_EN.
module ccr_branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_alu_zero,
    input  logic       i_alu_negative,
    input  logic       i_alu_carry,
    input  logic       i_flags_we,
    input  logic       i_setc,
    input  logic       i_clrc,
    input  logic       i_stall,
    input  logic       i_branch_valid,
    input  logic [1:0] i_branch_type,
    input  logic       i_int_save,
    input  logic       i_int_restore,
    output logic       o_zero_flag,
    output logic       o_negative_flag,
    output logic       o_carry_flag,
    output logic       o_branch_taken,
    output logic       o_flush,
    output logic       o_int_pending
);

    typedef enum logic {ST_NORMAL, ST_SAVED} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [1:0] BR_JZ = 2'b00, BR_JN = 2'b01, BR_JC = 2'b10;

    state_t     state_q;
    logic [2:0] ccr_q;      // {Z, N, C}
    logic [2:0] shadow_q;
    logic [2:0] flush_cnt;
    logic       flush_q;
    logic       pending_q;

    logic [2:0] base_flags;
    logic [2:0] ab_flags;
    logic [2:0] cond_flags;
    logic [2:0] nxt_flags;
    logic [2:0] commit_flags;
    logic [2:0] flush_nxt;
    logic       cond;
    logic       taken;

    always_comb begin
        base_flags = i_flags_we ? {i_alu_zero, i_alu_negative, i_alu_carry} : ccr_q;
        ab_flags   = base_flags;
        if (i_setc && !i_clrc)
            ab_flags[0] = 1'b1;
        else if (i_clrc && !i_setc)
            ab_flags[0] = 1'b0;
    end

`ifdef CCR_BYPASS_EN
    assign cond_flags = ab_flags;
`else
    assign cond_flags = ccr_q;
`endif

    always_comb begin
        cond = 1'b1;
        case (i_branch_type)
            BR_JZ:   cond = cond_flags[2];
            BR_JN:   cond = cond_flags[1];
            BR_JC:   cond = cond_flags[0];
            default: cond = 1'b1;
        endcase
    end

    // Branches seen while a flush is still running are wrong-path and ignored.
    assign taken = i_branch_valid && !i_stall && (flush_cnt == 3'd0) && cond;

    always_comb begin
        nxt_flags = ab_flags;
        if (taken) begin
            case (i_branch_type)
                BR_JZ:   nxt_flags[2] = 1'b0;
                BR_JN:   nxt_flags[1] = 1'b0;
                BR_JC:   nxt_flags[0] = 1'b0;
                default: nxt_flags = ab_flags;
            endcase
        end
        commit_flags = i_stall ? ccr_q : nxt_flags;
    end

    always_comb begin
        if (taken)
            flush_nxt = FLUSH_LOAD;
        else if (flush_cnt != 3'd0)
            flush_nxt = flush_cnt - 3'd1;
        else
            flush_nxt = 3'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_NORMAL;
            ccr_q     <= 3'b000;
            shadow_q  <= 3'b000;
            flush_cnt <= 3'd0;
            flush_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            ccr_q     <= commit_flags;
            flush_cnt <= flush_nxt;
            flush_q   <= (flush_nxt != 3'd0);
            case (state_q)
                ST_NORMAL: begin
                    if (i_int_save) begin
                        shadow_q  <= commit_flags;
                        state_q   <= ST_SAVED;
                        pending_q <= 1'b1;
                    end
                end
                ST_SAVED: begin
                    // Restore wins over ALU writes, SETC/CLRC, branch clears and stall.
                    if (i_int_restore) begin
                        ccr_q     <= shadow_q;
                        state_q   <= ST_NORMAL;
                        pending_q <= 1'b0;
                    end
                end
                default: state_q <= ST_NORMAL;
            endcase
        end
    end

    assign o_zero_flag     = ccr_q[2];
    assign o_negative_flag = ccr_q[1];
    assign o_carry_flag    = ccr_q[0];
    assign o_branch_taken  = taken;
    assign o_flush         = flush_q;
    assign o_int_pending   = pending_q;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Directed bench for ccr_branch_unit (FLUSH_CYCLES=2); expected values hand-computed, bypass expectations follow CCR_BYPASS_EN.
module tb_ccr_branch_unit;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_alu_zero, i_alu_negative, i_alu_carry;
    logic       i_flags_we, i_setc, i_clrc, i_stall;
    logic       i_branch_valid;
    logic [1:0] i_branch_type;
    logic       i_int_save, i_int_restore;
    logic       o_zero_flag, o_negative_flag, o_carry_flag;
    logic       o_branch_taken, o_flush, o_int_pending;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    ccr_branch_unit #(.FLUSH_CYCLES(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_alu_zero(i_alu_zero), .i_alu_negative(i_alu_negative), .i_alu_carry(i_alu_carry),
        .i_flags_we(i_flags_we), .i_setc(i_setc), .i_clrc(i_clrc), .i_stall(i_stall),
        .i_branch_valid(i_branch_valid), .i_branch_type(i_branch_type),
        .i_int_save(i_int_save), .i_int_restore(i_int_restore),
        .o_zero_flag(o_zero_flag), .o_negative_flag(o_negative_flag), .o_carry_flag(o_carry_flag),
        .o_branch_taken(o_branch_taken), .o_flush(o_flush), .o_int_pending(o_int_pending)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {1'b0, o_zero_flag, o_negative_flag, o_carry_flag};
    endfunction

    task automatic idle();
        i_reset = 1'b0; {i_alu_zero, i_alu_negative, i_alu_carry} = 3'b000;
        i_flags_we = 0; i_setc = 0; i_clrc = 0; i_stall = 0;
        i_branch_valid = 0; i_branch_type = 2'b00; i_int_save = 0; i_int_restore = 0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        idle();
    endtask

    task automatic alu(input logic [2:0] znc);
        i_flags_we = 1'b1;
        {i_alu_zero, i_alu_negative, i_alu_carry} = znc;
    endtask

    task automatic branch(input logic [1:0] t);
        i_branch_valid = 1'b1;
        i_branch_type  = t;
    endtask

    initial begin
        idle();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b1;
        tick();
        check("reset_flags", flags(), 4'b0000);
        check("reset_flush", {3'b0, o_flush}, 4'b0000);
        check("reset_pending", {3'b0, o_int_pending}, 4'b0000);
        check("reset_taken", {3'b0, o_branch_taken}, 4'b0000);

        // ALU load Z=1 N=0 C=1
        alu(3'b101);
        tick();
        check("alu_load", flags(), 4'b0101);
        check("alu_load_flush", {3'b0, o_flush}, 4'b0000);

        // JZ taken, clears Z, 2-cycle flush; JC during flush ignored
        branch(2'b00);
        #1 check("jz_taken", {3'b0, o_branch_taken}, 4'b0001);
        tick();
        check("jz_clear", flags(), 4'b0001);
        check("flush_c1", {3'b0, o_flush}, 4'b0001);
        branch(2'b10);
        #1 check("jc_wrongpath", {3'b0, o_branch_taken}, 4'b0000);
        tick();
        check("jc_keep_c", flags(), 4'b0001);
        check("flush_c2", {3'b0, o_flush}, 4'b0001);
        tick();
        check("flush_end", {3'b0, o_flush}, 4'b0000);

        // SETC beats ALU C=0; SETC+CLRC keeps C; CLRC clears
        alu(3'b000); i_setc = 1'b1;
        tick();
        check("setc_over_alu", flags(), 4'b0001);
        i_setc = 1'b1; i_clrc = 1'b1;
        tick();
        check("setc_clrc_hold", flags(), 4'b0001);
        i_clrc = 1'b1;
        tick();
        check("clrc", flags(), 4'b0000);

        // Interrupt save/restore
        alu(3'b101);
        tick();
        i_int_save = 1'b1;
        tick();
        check("save_pending", {3'b0, o_int_pending}, 4'b0001);
        alu(3'b010);
        tick();
        check("alu_in_saved", flags(), 4'b0010);
        i_int_save = 1'b1; alu(3'b000);
        tick();
        check("nested_save_pend", {3'b0, o_int_pending}, 4'b0001);
        check("nested_save_flags", flags(), 4'b0000);
        i_int_restore = 1'b1; alu(3'b111);
        tick();
        check("restore_flags", flags(), 4'b0101);
        check("restore_pending", {3'b0, o_int_pending}, 4'b0000);

        // Stall freezes CCR and branch
        alu(3'b100);
        tick();
        i_stall = 1'b1; alu(3'b011); branch(2'b00);
        #1 check("stall_taken", {3'b0, o_branch_taken}, 4'b0000);
        tick();
        check("stall_flags", flags(), 4'b0100);
        check("stall_flush", {3'b0, o_flush}, 4'b0000);

        // Same-cycle flag write then JZ
        alu(3'b000);
        tick();
        alu(3'b100); branch(2'b00);
`ifdef CCR_BYPASS_EN
        #1 check("bypass_taken", {3'b0, o_branch_taken}, 4'b0001);
        tick();
        check("bypass_flags", flags(), 4'b0000);
        check("bypass_flush", {3'b0, o_flush}, 4'b0001);
`else
        #1 check("nobypass_taken", {3'b0, o_branch_taken}, 4'b0000);
        tick();
        check("nobypass_flags", flags(), 4'b0100);
        check("nobypass_flush", {3'b0, o_flush}, 4'b0000);
`endif
        tick(); tick(); tick();

        // JN clears N only
        alu(3'b011);
        tick();
        branch(2'b01);
        #1 check("jn_taken", {3'b0, o_branch_taken}, 4'b0001);
        tick();
        check("jn_clear", flags(), 4'b0001);
        tick(); tick();
        check("jn_flush_done", {3'b0, o_flush}, 4'b0000);

        // JMP taken, no flag clear
        branch(2'b11);
        #1 check("jmp_taken", {3'b0, o_branch_taken}, 4'b0001);
        tick();
        check("jmp_flags", flags(), 4'b0001);

        // Reset while SAVED and mid-flush
        i_int_save = 1'b1;
        tick();
        check("pre_reset_pend", {3'b0, o_int_pending}, 4'b0001);
        check("pre_reset_flush", {3'b0, o_flush}, 4'b0001);
        i_reset = 1'b1;
        tick();
        check("mid_reset_flags", flags(), 4'b0000);
        check("mid_reset_flush", {3'b0, o_flush}, 4'b0000);
        check("mid_reset_pend", {3'b0, o_int_pending}, 4'b0000);
        i_int_restore = 1'b1;
        tick();
        check("snapshot_lost", flags(), 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
